// File: rtl/prepaid_pkg.sv
// Shared types and defaults for the prepaid supply controller.
// Holds the FSM state encoding, datapath width and default limits.
package prepaid_pkg;

  localparam int W = 10;

  localparam int LOW_LVL_DEF     = 45;
  localparam int CYCLE_DAYS_DEF  = 31;
  localparam int GRACE_DAYS_DEF  = 2;
  localparam int GRACE_UNITS_DEF = 8;

  typedef enum logic [2:0] {
    NORMAL = 3'd0,
    LOW    = 3'd1,
    GRACE  = 3'd2,
    CUTOFF = 3'd3,
    ROLL   = 3'd4,
    SETTLE = 3'd5
  } state_e;

endpackage

// File: rtl/billing_day_counter.sv
// Day-within-cycle counter, 1..CYCLE_DAYS, with a registered last-day flag.
// Ports: clk, reset, day_tick_i, cycle_end_o (on last day), day_cnt_o.
module billing_day_counter #(
  parameter int CYCLE_DAYS = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       day_tick_i,
  output logic       cycle_end_o,
  output logic [4:0] day_cnt_o
);

  logic [4:0] day_q;
  logic       end_q;

  // end_q marks the last day, so a day_tick while it is set
  // is the rollover tick and wraps the counter to day 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      day_q <= 5'd1;
      end_q <= 1'b0;
    end else if (day_tick_i) begin
      if (end_q) begin
        day_q <= 5'd1;
        end_q <= 1'b0;
      end else begin
        day_q <= day_q + 5'd1;
        end_q <= (day_q + 5'd1 == 5'(CYCLE_DAYS));
      end
    end
  end

  assign cycle_end_o = end_q;
  assign day_cnt_o   = day_q;

endmodule

// File: rtl/prepaid_supply_ctrl.sv
// Prepaid supply/billing controller: credit register, recharge
// handshake, relay FSM (NORMAL/LOW/GRACE/CUTOFF) and cycle rollover.
// Ports: clk, reset, day_tick, unit_pulse, balance, recharge_*,
// prepaid, unit_en, meter_clr, relay_on, low_alert, state, day_cnt.
module prepaid_supply_ctrl
  import prepaid_pkg::*;
#(
  parameter int LOW_LVL     = LOW_LVL_DEF,
  parameter int CYCLE_DAYS  = CYCLE_DAYS_DEF,
  parameter int GRACE_DAYS  = GRACE_DAYS_DEF,
  parameter int GRACE_UNITS = GRACE_UNITS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         day_tick,
  input  logic         unit_pulse,
  input  logic [W-1:0] balance,
  input  logic         recharge_valid,
  input  logic [W-1:0] recharge_amt,
  output logic         recharge_ready,
  output logic [W-1:0] prepaid,
  output logic         unit_en,
  output logic         meter_clr,
  output logic         relay_on,
  output logic         low_alert,
  output logic [2:0]   state,
  output logic [4:0]   day_cnt
);

  localparam int GCW = $clog2(GRACE_DAYS + 1);
  localparam int GUW = $clog2(GRACE_UNITS + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   prepaid_q, prepaid_d;
  logic [GCW-1:0] gcnt_q, gcnt_d;
  logic [GUW-1:0] gunits_q, gunits_d;
  logic           gused_q, gused_d;
  logic           relay_q, relay_d;
  logic           clr_q, clr_d;
  logic           ready_q, ready_d;

  logic           cycle_end;
  logic           roll;
  logic           accept;
  logic           expire;
  logic           do_eval;
  logic [W:0]     sum;

  billing_day_counter #(
    .CYCLE_DAYS (CYCLE_DAYS)
  ) u_day (
    .clk         (clk),
    .reset       (reset),
    .day_tick_i  (day_tick),
    .cycle_end_o (cycle_end),
    .day_cnt_o   (day_cnt)
  );

  assign unit_en = unit_pulse && relay_q;
  assign roll    = day_tick && cycle_end;
  // Rollover outranks recharge: ready is still high on the
  // rollover tick, so the handshake is masked here instead.
  assign accept  = recharge_valid && ready_q && !roll;
  assign sum     = {1'b0, prepaid_q} + {1'b0, recharge_amt};

  always_comb begin
    state_d  = state_q;
    prepaid_d = prepaid_q;
    gcnt_d   = gcnt_q;
    gunits_d = gunits_q;
    gused_d  = gused_q;
    expire   = 1'b0;
    do_eval  = 1'b0;

    if (accept) begin
      prepaid_d = sum[W] ? '1 : sum[W-1:0];
    end

    unique case (state_q)
      ROLL: begin
        state_d   = SETTLE;
        prepaid_d = balance;
        gused_d   = 1'b0;
      end
      SETTLE: do_eval = 1'b1;
      default: begin
        if (roll) begin
          state_d = ROLL;
        end else begin
          if (state_q == GRACE) begin
            if (day_tick) begin
              if (gcnt_q == GCW'(1)) expire = 1'b1;
              else gcnt_d = gcnt_q - GCW'(1);
            end
            if (unit_en) begin
              if (gunits_q == GUW'(GRACE_UNITS - 1))
                expire = 1'b1;
              else
                gunits_d = gunits_q + GUW'(1);
            end
          end
          if (expire) state_d = CUTOFF;
          // New credit is only visible on balance next cycle.
          else if (!accept) do_eval = 1'b1;
        end
      end
    endcase

    if (do_eval) begin
      if (balance > W'(LOW_LVL)) begin
        state_d = NORMAL;
      end else if (balance != '0) begin
        state_d = LOW;
      end else if (state_q == GRACE ||
                   state_q == CUTOFF) begin
        state_d = state_q;
      end else if (!gused_q) begin
        state_d  = GRACE;
        gcnt_d   = GCW'(GRACE_DAYS);
        gunits_d = '0;
        gused_d  = 1'b1;
      end else begin
        state_d = CUTOFF;
      end
    end

    ready_d = !(state_d == ROLL || state_d == SETTLE);
    clr_d   = (state_d == ROLL);
    relay_d = ready_d ? (state_d != CUTOFF) : relay_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= NORMAL;
      prepaid_q <= '0;
      gcnt_q    <= '0;
      gunits_q  <= '0;
      gused_q   <= 1'b0;
      relay_q   <= 1'b1;
      clr_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prepaid_q <= prepaid_d;
      gcnt_q    <= gcnt_d;
      gunits_q  <= gunits_d;
      gused_q   <= gused_d;
      relay_q   <= relay_d;
      clr_q     <= clr_d;
      ready_q   <= ready_d;
    end
  end

  assign state          = state_q;
  assign prepaid        = prepaid_q;
  assign relay_on       = relay_q;
  assign meter_clr      = clr_q;
  assign recharge_ready = ready_q;
  assign low_alert      = (state_q == LOW);

endmodule

// File: doc/prepaid_supply_ctrl.md
Name: prepaid_supply_ctrl

Overview:
Supply and billing controller for the prepaid energy meter. Owns the prepaid credit register that feeds the metering and tariff datapath, and accepts recharges over a valid/ready handshake. Gates meter pulses and drives the supply relay through a NORMAL/LOW/GRACE/CUTOFF state machine. Sequences the billing-cycle rollover: credit carry-forward plus a clear of the unit counter.

Parameters:
W, 10, width of credit, balance and recharge values
LOW_LVL, 45, balance at or below this value is LOW
CYCLE_DAYS, 31, day ticks per billing cycle
GRACE_DAYS, 2, days of supply allowed at zero balance
GRACE_UNITS, 8, maximum unit pulses allowed during grace

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
day_tick  in  1  one-cycle pulse per day
unit_pulse  in  1  one-cycle pulse per consumed unit, from the sensor
balance  in  W  remaining credit from the datapath (combinational, saturates at 0)
recharge_valid  in  1  recharge request
recharge_amt  in  W  recharge amount
recharge_ready  out  1  recharge accepted when valid&&ready
prepaid  out  W  credit register, feeds the datapath
unit_en  out  1  gated unit pulse to the unit counter
meter_clr  out  1  one-cycle synchronous clear of units and date in the datapath
relay_on  out  1  supply relay enable
low_alert  out  1  high in LOW state
state  out  3  current state encoding
day_cnt  out  5  day within cycle, 1..CYCLE_DAYS

Behaviour:
- Reset values: state=NORMAL, prepaid=0, day_cnt=1, grace_cnt=0, grace_units=0, grace_used=0, relay_on=1, meter_clr=0, recharge_ready=0 (registered as 1 from the first cycle after reset).
- unit_en = unit_pulse && relay_on. This path is combinational, with zero latency.
- Recharge:
  - recharge_ready=1 in NORMAL, LOW, GRACE and CUTOFF; 0 in ROLL and SETTLE.
  - On handshake, prepaid <= min(prepaid+recharge_amt, 2^W-1), i.e. saturating; carry is detected on a W+1-bit sum.
  - The new balance is visible on the next cycle. The state is re-evaluated on the cycle after that.
- Day counter:
  - On day_tick, day_cnt increments.
  - If day_cnt==CYCLE_DAYS on day_tick, the next state is ROLL, day_cnt <= 1 and the day_tick is consumed.
- Balance evaluation, in NORMAL, LOW and GRACE, when no rollover is pending:
  - balance > LOW_LVL -> NORMAL.
  - 0 < balance <= LOW_LVL -> LOW.
  - balance==0 and !grace_used -> GRACE; grace_cnt <= GRACE_DAYS, grace_units <= 0, grace_used <= 1.
  - balance==0 and grace_used -> CUTOFF.
- GRACE:
  - relay_on=1.
  - day_tick decrements grace_cnt; unit_en increments grace_units.
  - Goes to CUTOFF when grace_cnt==1 on a day_tick, or when a unit arrives with grace_units==GRACE_UNITS-1.
  - balance>0 (after a recharge) -> LOW or NORMAL by the evaluation rule above.
- CUTOFF:
  - relay_on=0; unit pulses are dropped.
  - balance>0 -> LOW or NORMAL. Relay re-closes on the same edge as the state change.
- ROLL (1 cycle):
  - meter_clr=1; prepaid <= balance (credit carry-forward); grace_used <= 0.
  - relay_on holds its previous value.
  - Next state is SETTLE.
- SETTLE (1 cycle):
  - Lets the datapath settle with units=0.
  - Next state is chosen by the balance evaluation rule, so carried credit of 0 gives GRACE.
- Priority when events coincide in one cycle: reset > rollover > recharge > grace expiry > balance evaluation.
  - A recharge presented with a rollover day_tick is not accepted, because ready drops from the next cycle; it remains pending under the handshake rules.
  - Recharge and grace expiry together: the recharge is accepted and the state goes to CUTOFF, then returns to LOW or NORMAL two cycles later.
- Unit pulses during ROLL are forwarded. The datapath clear wins, so that unit is absorbed.
- Reset mid-operation: all registers return to reset values immediately; credit is lost.
- low_alert = (state==LOW).

Decomposition:
- Shared package prepaid_pkg holds:
  - state enum: NORMAL=0, LOW=1, GRACE=2, CUTOFF=3, ROLL=4, SETTLE=5;
  - W;
  - default LOW_LVL, CYCLE_DAYS, GRACE_DAYS, GRACE_UNITS.
- One sub-module, billing_day_counter: day_cnt plus a registered cycle_end strobe.
- The FSM, credit register and grace counters stay in the top level.

Test Plan:
- Reset, then recharge 100 with ready=1 -> prepaid=100; NORMAL 2 cycles later; relay_on=1.
- Recharge 1000 on top of prepaid=100 -> prepaid=1023 (saturated).
- Drive balance 46 -> 45 -> NORMAL to LOW, low_alert=1; balance 0 -> GRACE, grace_cnt=2; two day_ticks -> CUTOFF, relay_on=0, unit_pulse gives unit_en=0.
- In GRACE, 8 unit_pulses -> CUTOFF on the 8th; recharge 50 -> balance 50 -> NORMAL, relay_on=1; balance 0 again in the same cycle -> CUTOFF directly (grace_used).
- 31 day_ticks with balance=60 -> ROLL: meter_clr high exactly 1 cycle, prepaid=60, then SETTLE, then NORMAL, day_cnt=1.
- recharge_valid on the rollover day_tick cycle -> not accepted; ready=0 in ROLL and SETTLE; accepted in the first cycle after SETTLE, amount added to the carried credit.
